noc_buffer_in: RTL and testbench

Inbound store-and-forward packet buffer between the NoC router port and the tile's consumer logic. Single-clock mirror of the outbound buffer. Accepts AXI-Stream beats from the NoC and stores them in a local FIFO. Presents a packet downstream only once its TLAST beat is stored, so the consumer never sees a partial packet or a mid-packet bubble caused by the NoC.

---
 rtl/noc_buffer_in_pkg.sv | 24 ++
 rtl/noc_buffer_in_sdp_ram.sv | 37 +++
 rtl/noc_buffer_in.sv | 150 +++++++++++++++
 tb/tb_noc_buffer_in.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_buffer_in_pkg.sv
// noc_buf_pkg: shared types and helpers for the inbound NoC packet buffer.
//   state_t  - output FSM states (IDLE, SEND)
//   data_w() - stored beat width for a given stream width: data + keep + last
//   beat_t   - packed {last, keep, data} beat at the default 32-bit width
package noc_buf_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  function automatic int data_w(input int bw);
    return bw + bw / 8 + 1;
  endfunction

  localparam int BW_DEFAULT = 32;

  typedef struct packed {
    logic                      last;
    logic [BW_DEFAULT/8-1:0]   keep;
    logic [BW_DEFAULT-1:0]     data;
  } beat_t;

endpackage

// File: rtl/noc_buffer_in_sdp_ram.sv
// noc_sdp_ram: simple dual-port RAM, 2**ADDR_W x DATA_W.
//   clk     - clock
//   rst_n   - async active-low reset (read register only; array is not reset)
//   i_we    - write enable,  i_waddr/i_wdata - write address/data
//   i_re    - read enable,   i_raddr         - read address
//   o_rdata - registered read data, updated one cycle after i_re, held otherwise
module noc_sdp_ram #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 37
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/noc_buffer_in.sv
// noc_buffer_in: inbound store-and-forward packet buffer (NoC -> tile).
// Beats are stored in a local FIFO; a packet is presented downstream only
// once its TLAST beat is stored, so the consumer never sees partial packets
// or NoC-induced mid-packet bubbles.
//   clk_in, clk_in_rst_low       - clock, async active-low reset
//   stream_in_*                  - AXI-Stream from NoC (TREADY registered)
//   stream_out_*                 - AXI-Stream to consumer
// Optional macro NOC_BUFFER_IN_STATS_EN adds pkt_in_cnt, pkt_out_cnt, occ_max.
module noc_buffer_in
  import noc_buf_pkg::*;
#(
  parameter int unsigned BW     = 32,
  parameter int unsigned BWB    = BW / 8,
  parameter int unsigned ADDR_W = 8
) (
  input  logic           clk_in,
  input  logic           clk_in_rst_low,
  input  logic           stream_in_TVALID,
  input  logic [BW-1:0]  stream_in_TDATA,
  input  logic [BWB-1:0] stream_in_TKEEP,
  input  logic           stream_in_TLAST,
  output logic           stream_in_TREADY,
  output logic           stream_out_TVALID,
  output logic [BW-1:0]  stream_out_TDATA,
  output logic [BWB-1:0] stream_out_TKEEP,
  output logic           stream_out_TLAST,
  input  logic           stream_out_TREADY
`ifdef NOC_BUFFER_IN_STATS_EN
  ,
  output logic [15:0]    pkt_in_cnt,
  output logic [15:0]    pkt_out_cnt,
  output logic [ADDR_W:0] occ_max
`endif
);

  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned DATA_W = data_w(BW);
  localparam logic [ADDR_W:0]   OCC_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   READY_MAX = (ADDR_W+1)'(DEPTH - 2);

  typedef struct packed {
    logic           last;
    logic [BWB-1:0] keep;
    logic [BW-1:0]  data;
  } beat_p_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [ADDR_W:0]   r_occ, w_occ_nxt;
  logic [ADDR_W:0]   r_pkts, w_pkts_nxt;
  logic              r_in_ready;
  logic              w_wr, w_in_last, w_rd, w_out_hs, w_out_last_hs;
  beat_p_t           w_wbeat, w_rbeat;
  logic [DATA_W-1:0] w_rdata;

  assign w_wr      = stream_in_TVALID & r_in_ready;
  assign w_in_last = w_wr & stream_in_TLAST;
  assign w_wbeat   = '{last: stream_in_TLAST, keep: stream_in_TKEEP, data: stream_in_TDATA};
  assign w_rbeat   = w_rdata;

  noc_sdp_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk_in),
    .rst_n   (clk_in_rst_low),
    .i_we    (w_wr),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wbeat),
    .i_re    (w_rd),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  assign stream_in_TREADY  = r_in_ready;
  assign stream_out_TVALID = (r_state == SEND);
  assign stream_out_TDATA  = w_rbeat.data;
  assign stream_out_TKEEP  = w_rbeat.keep;
  assign stream_out_TLAST  = w_rbeat.last;
  assign w_out_hs          = stream_out_TVALID & stream_out_TREADY;
  assign w_out_last_hs     = w_out_hs & w_rbeat.last;

  // Reads are only issued for beats of complete packets, so a non-last
  // handshake can always fetch the next beat without checking occupancy.
  always_comb begin
    w_state_nxt = r_state;
    w_rd        = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (r_pkts != '0) begin
          w_rd        = 1'b1;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        if (stream_out_TREADY) begin
          if (!w_rbeat.last || (r_pkts > OCC_ONE)) w_rd = 1'b1;
          else                                     w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Occupancy is released on the output handshake, not on the RAM read, so
  // the beat parked in the output register still holds its slot.
  always_comb begin
    w_occ_nxt = r_occ;
    if (w_wr && !w_out_hs)      w_occ_nxt = r_occ + OCC_ONE;
    else if (!w_wr && w_out_hs) w_occ_nxt = r_occ - OCC_ONE;

    w_pkts_nxt = r_pkts;
    if (w_in_last && !w_out_last_hs)      w_pkts_nxt = r_pkts + OCC_ONE;
    else if (!w_in_last && w_out_last_hs) w_pkts_nxt = r_pkts - OCC_ONE;
  end

  always_ff @(posedge clk_in or negedge clk_in_rst_low) begin
    if (!clk_in_rst_low) begin
      r_state    <= IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_occ      <= '0;
      r_pkts     <= '0;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_occ      <= w_occ_nxt;
      r_pkts     <= w_pkts_nxt;
      r_in_ready <= (w_occ_nxt <= READY_MAX);
      if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

`ifdef NOC_BUFFER_IN_STATS_EN
  always_ff @(posedge clk_in or negedge clk_in_rst_low) begin
    if (!clk_in_rst_low) begin
      pkt_in_cnt  <= '0;
      pkt_out_cnt <= '0;
      occ_max     <= '0;
    end else begin
      if (w_in_last)           pkt_in_cnt  <= pkt_in_cnt + 16'd1;
      if (w_out_last_hs)       pkt_out_cnt <= pkt_out_cnt + 16'd1;
      if (w_occ_nxt > occ_max) occ_max     <= w_occ_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_noc_buffer_in.sv
// Self-checking bench for noc_buffer_in (BW=32, ADDR_W=4: 16 entries, 15 beats).
// A queue of accepted-but-not-consumed beats is the reference: output beats
// must leave in arrival order, only when a complete packet is held, without
// bubbles inside a packet, and TREADY must reflect free space.
module tb_noc_buffer_in;

  localparam int BW     = 32;
  localparam int BWB    = 4;
  localparam int ADDR_W = 4;
  localparam int CAP    = 15;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic [BW-1:0]  in_data = '0;
  logic [BWB-1:0] in_keep = '0;
  logic           in_last = 1'b0;
  logic           in_ready;
  logic           out_valid;
  logic [BW-1:0]  out_data;
  logic [BWB-1:0] out_keep;
  logic           out_last;
  logic           out_ready = 1'b0;
`ifdef NOC_BUFFER_IN_STATS_EN
  logic [15:0]     pkt_in_cnt, pkt_out_cnt;
  logic [ADDR_W:0] occ_max;
`endif

  always #5 clk = ~clk;

  noc_buffer_in #(.BW(BW), .BWB(BWB), .ADDR_W(ADDR_W)) dut (
    .clk_in            (clk),
    .clk_in_rst_low    (rst_n),
    .stream_in_TVALID  (in_valid),
    .stream_in_TDATA   (in_data),
    .stream_in_TKEEP   (in_keep),
    .stream_in_TLAST   (in_last),
    .stream_in_TREADY  (in_ready),
    .stream_out_TVALID (out_valid),
    .stream_out_TDATA  (out_data),
    .stream_out_TKEEP  (out_keep),
    .stream_out_TLAST  (out_last),
    .stream_out_TREADY (out_ready)
`ifdef NOC_BUFFER_IN_STATS_EN
    ,
    .pkt_in_cnt        (pkt_in_cnt),
    .pkt_out_cnt       (pkt_out_cnt),
    .occ_max           (occ_max)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model state (owned by the monitor).
  logic [36:0] model[$];
  int          since_rst = 0;
  bit          prev_hold = 0;
  bit          prev_mid = 0;
  logic [37:0] prev_view;
  int          hs_cnt = 0;
  int          out_last_cnt = 0;
  int          in_last_cnt = 0;
  int          peak = 0;
  logic [36:0] m_obs;
  logic [37:0] m_exp;
  bit          m_in_hs, m_out_hs;
  bit          done = 0;

  function automatic bit has_complete();
    foreach (model[i]) if (model[i][36]) return 1'b1;
    return 1'b0;
  endfunction

  // Handshakes decided at the negedge complete at the following posedge.
  always @(negedge clk) begin
    if (!rst_n) begin
      model.delete();
      since_rst    = 0;
      prev_hold    = 0;
      prev_mid     = 0;
      in_last_cnt  = 0;
      out_last_cnt = 0;
      peak         = 0;
    end else begin
      m_obs    = {out_last, out_keep, out_data};
      m_in_hs  = in_valid & in_ready;
      m_out_hs = out_valid & out_ready;
      if (since_rst > 0) check("in_ready", in_ready, model.size() <= CAP - 1);
      since_rst++;
      if (prev_hold) check("hold_stable", {out_valid, m_obs}, prev_view);
      if (prev_mid)  check("no_bubble", out_valid, 1'b1);
      if (out_valid) check("complete_pkt", has_complete(), 1'b1);
      if (m_out_hs) begin
        m_exp = (model.size() > 0) ? {1'b0, model.pop_front()} : {1'b1, 37'h0};
        check("out_beat", {1'b0, m_obs}, m_exp);
        hs_cnt++;
        if (m_obs[36]) out_last_cnt++;
      end
      if (m_in_hs) begin
        model.push_back({in_last, in_keep, in_data});
        if (in_last) in_last_cnt++;
      end
      if (model.size() > peak) peak = model.size();
      check("capacity", model.size() <= CAP, 1'b1);
      prev_hold = out_valid & ~out_ready;
      prev_view = {out_valid, m_obs};
      prev_mid  = m_out_hs & ~m_obs[36];
    end
  end

  // All drive tasks start and end at posedge+1.
  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_keep = k; in_last = l;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) check("in_timeout", n, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_pkt(input int len, input logic [31:0] base);
    for (int i = 0; i < len; i++)
      send_beat(base + i, (i == len - 1) ? 4'h3 : 4'hF, i == len - 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) check("out_timeout", n, 0);
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (model.size() != 0 && n < 500) begin @(posedge clk); #1; n++; end
    idle(2);
    check("drain_empty", model.size(), 0);
  endtask

  int h0;
  int vcnt;
  bit seen;
  bit pat[7] = '{1, 0, 0, 1, 0, 1, 1};

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_beat", {out_last, out_keep, out_data}, 37'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_pre_edge", in_ready, 1'b0);
    @(posedge clk); #1;
    check("ready_first_edge", in_ready, 1'b1);

    // Basic 3-beat packet and TLAST-to-TVALID latency.
    out_ready = 1'b1;
    h0 = hs_cnt;
    send_beat(32'h11, 4'hF, 1'b0);
    send_beat(32'h22, 4'hF, 1'b0);
    send_beat(32'h33, 4'h3, 1'b1);
    @(negedge clk); check("lat_t1", out_valid, 1'b0);
    @(negedge clk); check("lat_t2", out_valid, 1'b1);
    repeat (3) @(negedge clk);
    check("basic_end_valid", out_valid, 1'b0);
    @(posedge clk); #1;
    check("basic_hs", hs_cnt - h0, 3);

    // Partial packet must stay hidden.
    send_beat(32'hA0, 4'hF, 1'b0);
    send_beat(32'hA1, 4'hF, 1'b0);
    seen = 0;
    repeat (20) begin @(negedge clk); seen |= out_valid; end
    check("partial_hidden", seen, 1'b0);
    @(posedge clk); #1;
    h0 = hs_cnt;
    send_beat(32'hA2, 4'h3, 1'b1);
    drain();
    check("partial_hs", hs_cnt - h0, 3);

    // Fill with 15 single-beat packets while the consumer stalls.
    out_ready = 1'b0;
    for (int i = 0; i < 15; i++) send_beat(i, 4'hF, 1'b1);
    check("fill_ready_low", in_ready, 1'b0);
    check("fill_stored", model.size(), 15);
    out_ready = 1'b1;
    h0 = hs_cnt;
    vcnt = 0;
    repeat (15) begin @(negedge clk); if (out_valid) vcnt++; end
    check("fill_contiguous", vcnt, 15);
    @(posedge clk); #1;
    check("fill_hs", hs_cnt - h0, 15);
    check("fill_ready_back", in_ready, 1'b1);
    drain();

    // Output back-pressure pattern.
    out_ready = 1'b0;
    h0 = hs_cnt;
    vcnt = out_last_cnt;
    send_pkt(4, 32'hB0);
    wait_valid();
    foreach (pat[i]) begin out_ready = pat[i]; @(posedge clk); #1; end
    check("stall_hs", hs_cnt - h0, 4);
    check("stall_last", out_last_cnt - vcnt, 1);
    drain();

    // Asynchronous reset while beat 2 of 4 is presented.
    out_ready = 1'b0;
    send_pkt(4, 32'hC0);
    wait_valid();
    out_ready = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", out_valid, 1'b0);
    check("rst_async_ready", in_ready, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); check("rst2_ready_pre", in_ready, 1'b0);
    @(posedge clk); #1; check("rst2_ready", in_ready, 1'b1);
    h0 = hs_cnt;
    send_pkt(2, 32'hD0);
    drain();
    check("rst2_hs", hs_cnt - h0, 2);

    // Randomized traffic with random consumer back-pressure.
    done = 0;
    fork
      begin
        for (int p = 0; p < 60; p++) begin
          int len = $urandom_range(1, 8);
          for (int b = 0; b < len; b++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            send_beat($urandom, (b == len - 1) ? 4'($urandom_range(1, 15)) : 4'hF, b == len - 1);
          end
        end
        done = 1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
      end
    join
    drain();

`ifdef NOC_BUFFER_IN_STATS_EN
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    send_pkt(2, 32'hE0);
    send_pkt(1, 32'hE2);
    send_pkt(3, 32'hE3);
    send_pkt(1, 32'hE6);
    send_pkt(2, 32'hE7);
    out_ready = 1'b1;
    vcnt = 0;
    while (out_last_cnt < 3 && vcnt < 100) begin @(posedge clk); #1; vcnt++; end
    out_ready = 1'b0;
    idle(2);
    check("stats_in", pkt_in_cnt, 16'd5);
    check("stats_out", pkt_out_cnt, 16'd3);
    check("stats_occ_max", occ_max, 9);
    drain();
    for (int i = 5; i < 65536; i++) send_beat(i, 4'hF, 1'b1);
    drain();
    check("stats_in_wrap", pkt_in_cnt, 16'd0);
    check("stats_out_wrap", pkt_out_cnt, 16'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
